// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the fp32 divider issue front-end.
package fpu_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int FLG_NAN  = 3;
   localparam int FLG_INF  = 2;
   localparam int FLG_ZERO = 1;
   localparam int FLG_DEN  = 0;

   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam int MAN_MSB = 22;

   // Worst-case divider latency; the fixed wait must cover it.
   localparam int DIV_MIN_LAT = 176;

endpackage

// File: rtl/fpu_fp32_classify.sv
// Combinational fp32 classifier: {nan, inf, zero, denorm}, all clear for normals.
module fpu_fp32_classify
   import fpu_div_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [3:0]  o_flags
);

   logic [EXP_MSB-EXP_LSB:0] w_exp;
   logic [MAN_MSB:0]         w_man;
   logic                     w_exp_max;
   logic                     w_exp_min;
   logic                     w_man_nz;

   assign w_exp     = i_word[EXP_MSB:EXP_LSB];
   assign w_man     = i_word[MAN_MSB:0];
   assign w_exp_max = &w_exp;
   assign w_exp_min = ~|w_exp;
   assign w_man_nz  = |w_man;

   always_comb begin
      o_flags           = '0;
      o_flags[FLG_NAN]  = w_exp_max &  w_man_nz;
      o_flags[FLG_INF]  = w_exp_max & ~w_man_nz;
      o_flags[FLG_ZERO] = w_exp_min & ~w_man_nz;
      o_flags[FLG_DEN]  = w_exp_min &  w_man_nz;
   end

endmodule

// File: rtl/fpu_div_issue.sv
// Issue/response front-end for the fp32 divider: one divide in flight, fixed-latency
// capture of the divider result, tagged response with classification flags.
//
// state | meaning
// IDLE  | waiting for a request (blocked while div_rst is high)
// ISSUE | one cycle, div_dval pulsed, wait counter loaded
// WAIT  | counting down the divider worst-case latency
// RESP  | response valid, held until rsp_ready
module fpu_div_issue
   import fpu_div_pkg::*;
#(
   parameter int TAG_W       = 4,
   parameter int WAIT_CYCLES = 192,
   parameter int RST_SYNC    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             div_rst,
   output logic [31:0]      div_din1,
   output logic [31:0]      div_din2,
   output logic             div_dval,
   input  logic [31:0]      div_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       rsp_flags
);

   localparam int              CNT_W    = $clog2(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < DIV_MIN_LAT) begin : g_wait_chk
      $fatal(1, "fpu_div_issue: WAIT_CYCLES=%0d is below divider latency %0d",
             WAIT_CYCLES, DIV_MIN_LAT);
   end

   if (RST_SYNC < 1) begin : g_sync_chk
      $fatal(1, "fpu_div_issue: RST_SYNC must be at least 1");
   end

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [RST_SYNC-1:0] r_rst_sync;
   logic [31:0]         r_a;
   logic [31:0]         r_b;
   logic [TAG_W-1:0]    r_tag;
   logic [31:0]         r_rsp_data;
   logic [TAG_W-1:0]    r_rsp_tag;
   logic [3:0]          r_rsp_flags;
   logic [3:0]          w_flags;
   logic                w_accept;

   // Set asynchronously, released by shifting zeros in on clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_sync <= '1;
      end else begin
         r_rst_sync <= r_rst_sync << 1;
      end
   end

   assign div_rst   = r_rst_sync[RST_SYNC-1];
   assign req_ready = (r_state == IDLE) && !div_rst;
   assign w_accept  = req_valid && req_ready;

   fpu_fp32_classify u_classify (
      .i_word  (div_result),
      .o_flags (w_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_tag       <= '0;
         r_rsp_data  <= '0;
         r_rsp_tag   <= '0;
         r_rsp_flags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= req_a;
                  r_b     <= req_b;
                  r_tag   <= req_tag;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= CNT_LOAD;
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_data  <= div_result;
                  r_rsp_flags <= w_flags;
                  r_rsp_tag   <= r_tag;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Operands stay on the divider inputs from ISSUE until the next accept.
   assign div_din1  = r_a;
   assign div_din2  = r_b;
   assign div_dval  = (r_state == ISSUE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_tag   = r_rsp_tag;
   assign rsp_flags = r_rsp_flags;

endmodule
